// File: rtl/mtd_pkg.sv
// rtl/mtd_pkg.sv - shared types and constants for the multi-channel tick divider
package mtd_pkg;

  typedef enum logic {
    MODE_PULSE  = 1'b0,
    MODE_SQUARE = 1'b1
  } mode_e;

  localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/tick_channel.sv
// rtl/tick_channel.sv - one divider channel: counter, phase, shadow/active config, registered output
module tick_channel
  import mtd_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic             restart,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_div,
  input  mode_e            cfg_mode,
  output logic [WIDTH-1:0] active_div,
  output logic             fire,
  output logic             out
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] act_div_q, act_div_d;
  logic [WIDTH-1:0] shd_div_q, shd_div_d;
  mode_e            act_mode_q, act_mode_d;
  mode_e            shd_mode_q, shd_mode_d;
  logic             phase_q, phase_d;
  logic             out_q, out_d;
  logic             hit;

  assign hit        = step && (cnt_q == act_div_q);
  assign fire       = hit && !restart;
  assign active_div = act_div_q;
  assign out        = out_q;

  always_comb begin
    shd_div_d  = shd_div_q;
    shd_mode_d = shd_mode_q;
    if (cfg_load) begin
      shd_div_d  = cfg_div;
      shd_mode_d = cfg_mode;
    end

    // Active config only changes at a period boundary, so a write landing on the
    // same edge as that boundary takes effect at once.
    act_div_d  = act_div_q;
    act_mode_d = act_mode_q;
    if (hit || !en || restart) begin
      act_div_d  = shd_div_d;
      act_mode_d = shd_mode_d;
    end

    cnt_d   = cnt_q;
    phase_d = phase_q;
    out_d   = 1'b0;
    if (restart || !en) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else begin
      if (hit) begin
        cnt_d   = '0;
        phase_d = !phase_q;
      end else if (step) begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      out_d = (act_mode_d == MODE_SQUARE) ? phase_d : fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      act_div_q  <= WIDTH'(DEFAULT_DIV);
      shd_div_q  <= WIDTH'(DEFAULT_DIV);
      act_mode_q <= MODE_PULSE;
      shd_mode_q <= MODE_PULSE;
      phase_q    <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      act_div_q  <= act_div_d;
      shd_div_q  <= shd_div_d;
      act_mode_q <= act_mode_d;
      shd_mode_q <= shd_mode_d;
      phase_q    <= phase_d;
      out_q      <= out_d;
    end
  end

endmodule

// File: rtl/multi_tick_divider.sv
// rtl/multi_tick_divider.sv - multi-channel programmable clock-enable generator
// Optional MTD_CASCADE_EN: channel i>0 with cascade[i]=1 steps only on channel i-1 fires.
module multi_tick_divider
  import mtd_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int DEFAULT_DIV = 8,
  parameter int CH_BITS     = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ch_en,
  input  logic                cfg_wr,
  input  logic [CH_BITS-1:0]  cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  input  logic                cfg_mode,
  input  logic                restart,
  input  logic [CHANNELS-1:0] cascade,
  output logic [WIDTH-1:0]    rd_div,
  output logic [CHANNELS-1:0] out
);

  logic [WIDTH-1:0]    act_div [CHANNELS];
  logic [CHANNELS-1:0] unused_fire;
  logic                unused_cascade;

  assign unused_cascade = ^cascade;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Per-channel scalars keep the cascade chain acyclic at signal granularity.
    logic qual;
    logic fire;

    if (i == 0) begin : g_first
      assign qual = 1'b1;
    end else begin : g_next
`ifdef MTD_CASCADE_EN
      assign qual = !cascade[i] || g_ch[i-1].fire;
`else
      assign qual = 1'b1;
`endif
    end

    assign unused_fire[i] = fire;

    tick_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .en         (ch_en[i]),
      .step       (ch_en[i] && qual),
      .restart    (restart),
      .cfg_load   (cfg_wr && (cfg_ch == CH_BITS'(i))),
      .cfg_div    (cfg_div),
      .cfg_mode   (mode_e'(cfg_mode)),
      .active_div (act_div[i]),
      .fire       (fire),
      .out        (out[i])
    );
  end

  always_comb begin
    rd_div = '0;
    if (int'(cfg_ch) < CHANNELS) rd_div = act_div[cfg_ch];
  end

endmodule
